// File: rtl/phase_acc_rx.sv
// AXI4-Stream phase-increment sink: buffers increments in a small FIFO and
// streams the top bits of a 32-bit phase accumulator, one step per output beat.
module phase_acc_rx #(
  parameter int DEPTH = 4,
  parameter int OUT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              s_axis_phase_tdata,
  input  logic                     s_axis_phase_tvalid,
  input  logic                     s_axis_phase_tlast,
  output logic                     s_axis_phase_tready,
  output logic [OUT_W-1:0]         m_axis_data_tdata,
  output logic                     m_axis_data_tvalid,
  input  logic                     m_axis_data_tready,
  output logic [31:0]              active_inc,
  output logic                     phase_wrap,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, RUN} state_t;

  logic [32:0] mem_q [DEPTH];
  logic [AW:0] wr_q, rd_q;
  state_t      state_q;
  logic [31:0] acc_q;
  logic [31:0] inc_q;
  logic        wrap_q;

  logic        full, empty, push, pop, hs;
  logic [32:0] head;
  logic [31:0] head_data;
  logic        head_last;
  logic [32:0] sum_d;

  assign fifo_level = wr_q - rd_q;
  assign full       = (fifo_level == (AW+1)'(DEPTH));
  assign empty      = (wr_q == rd_q);

  assign s_axis_phase_tready = !full && !reset;
  assign push = s_axis_phase_tvalid && s_axis_phase_tready;
  assign hs   = m_axis_data_tvalid && m_axis_data_tready;
  // IDLE drains the FIFO freely; RUN only advances on an output beat
  assign pop  = !empty && ((state_q == IDLE) || hs);

  assign head      = mem_q[rd_q[AW-1:0]];
  assign head_data = head[31:0];
  assign head_last = head[32];

  assign sum_d = {1'b0, acc_q} + {1'b0, inc_q};

  assign m_axis_data_tdata  = acc_q[31 -: OUT_W];
  assign m_axis_data_tvalid = (state_q == RUN);
  assign active_inc         = inc_q;
  assign phase_wrap         = wrap_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_q[AW-1:0]] <= {s_axis_phase_tlast, s_axis_phase_tdata};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + (AW+1)'(1);
      if (pop)  rd_q <= rd_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      inc_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (!empty) begin
            inc_q <= head_data;
            if (head_data != '0) begin
              acc_q   <= '0;
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          if (hs) begin
            acc_q  <= sum_d[31:0];
            wrap_q <= sum_d[32];
            if (!empty) begin
              inc_q <= head_data;
              if (head_last) begin
                acc_q  <= '0;
                wrap_q <= 1'b0;
              end
              if (head_data == '0) state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_phase_acc_rx.sv
// Bench for phase_acc_rx: directed vector table, corner sequences and a
// randomized run against a queue-based reference model.
module tb_phase_acc_rx;

  localparam int DEPTH = 4;
  localparam int OUT_W = 16;

  logic        clk;
  logic        reset;
  logic [31:0] s_tdata;
  logic        s_tvalid;
  logic        s_tlast;
  logic        s_tready;
  logic [15:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic [31:0] active_inc;
  logic        phase_wrap;
  logic [2:0]  fifo_level;

  phase_acc_rx #(.DEPTH(DEPTH), .OUT_W(OUT_W)) dut (
    .clk                 (clk),
    .reset               (reset),
    .s_axis_phase_tdata  (s_tdata),
    .s_axis_phase_tvalid (s_tvalid),
    .s_axis_phase_tlast  (s_tlast),
    .s_axis_phase_tready (s_tready),
    .m_axis_data_tdata   (m_tdata),
    .m_axis_data_tvalid  (m_tvalid),
    .m_axis_data_tready  (m_tready),
    .active_inc          (active_inc),
    .phase_wrap          (phase_wrap),
    .fifo_level          (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic        last;
    logic [31:0] data;
  } beat_t;

  beat_t       mq[$];
  bit          m_run;
  logic [31:0] m_acc;
  logic [31:0] m_inc;
  bit          m_wrap;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_run  = 0;
    m_acc  = 0;
    m_inc  = 0;
    m_wrap = 0;
  endtask

  // One clock edge of the reference behaviour; pops see the pre-edge queue
  task automatic model_edge(bit v, logic [31:0] d, bit l, bit mr);
    bit     do_push;
    beat_t  e;
    longint s;
    do_push = v && (mq.size() < DEPTH);
    m_wrap  = 0;
    if (!m_run) begin
      if (mq.size() > 0) begin
        e = mq.pop_front();
        m_inc = e.data;
        if (e.data != 0) begin
          m_acc = 0;
          m_run = 1;
        end
      end
    end else if (mr) begin
      s      = longint'(m_acc) + longint'(m_inc);
      m_acc  = s[31:0];
      m_wrap = (s >= 64'h1_0000_0000);
      if (mq.size() > 0) begin
        e = mq.pop_front();
        m_inc = e.data;
        if (e.last) begin
          m_acc  = 0;
          m_wrap = 0;
        end
        if (e.data == 0) m_run = 0;
      end
    end
    if (do_push) mq.push_back('{last: l, data: d});
  endtask

  task automatic cmp_model();
    chk("m_tvalid", 32'(m_tvalid), 32'(m_run));
    chk("m_tdata", 32'(m_tdata), 32'(m_acc[31:16]));
    chk("active_inc", active_inc, m_inc);
    chk("phase_wrap", 32'(phase_wrap), 32'(m_wrap));
    chk("fifo_level", 32'(fifo_level), 32'(mq.size()));
    chk("s_tready", 32'(s_tready), 32'(mq.size() < DEPTH));
  endtask

  // Called at a negedge: drive, take one edge, compare at the next negedge
  task automatic step(bit v, logic [31:0] d, bit l, bit mr);
    s_tvalid = v;
    s_tdata  = d;
    s_tlast  = l;
    m_tready = mr;
    @(posedge clk);
    model_edge(v, d, l, mr);
    @(negedge clk);
    cmp_model();
  endtask

  task automatic reset_now();
    s_tvalid = 0;
    m_tready = 0;
    reset = 1'b1;
    #1;
    chk("rst_tready", 32'(s_tready), 32'd0);
    chk("rst_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_tdata", 32'(m_tdata), 32'd0);
    chk("rst_inc", active_inc, 32'd0);
    chk("rst_wrap", 32'(phase_wrap), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    bit          v;
    logic [31:0] d;
    bit          l;
    bit          mr;
    bit          e_valid;
    logic [15:0] e_data;
    logic [31:0] e_inc;
    bit          e_wrap;
    int          e_lvl;
  } vec_t;

  vec_t tbl[13];

  logic [15:0] ps_exp[8];

  initial begin
    tbl[0]  = '{1, 32'h0051EB85, 0, 1, 0, 16'h0000, 32'h00000000, 0, 1};
    tbl[1]  = '{0, 32'h0,        0, 1, 1, 16'h0000, 32'h0051EB85, 0, 0};
    tbl[2]  = '{0, 32'h0,        0, 1, 1, 16'h0051, 32'h0051EB85, 0, 0};
    tbl[3]  = '{0, 32'h0,        0, 1, 1, 16'h00A3, 32'h0051EB85, 0, 0};
    tbl[4]  = '{0, 32'h0,        0, 1, 1, 16'h00F5, 32'h0051EB85, 0, 0};
    tbl[5]  = '{1, 32'h0,        0, 1, 1, 16'h0147, 32'h0051EB85, 0, 1};
    tbl[6]  = '{0, 32'h0,        0, 1, 0, 16'h0199, 32'h00000000, 0, 0};
    tbl[7]  = '{1, 32'h80000000, 0, 1, 0, 16'h0199, 32'h00000000, 0, 1};
    tbl[8]  = '{0, 32'h0,        0, 1, 1, 16'h0000, 32'h80000000, 0, 0};
    tbl[9]  = '{0, 32'h0,        0, 1, 1, 16'h8000, 32'h80000000, 0, 0};
    tbl[10] = '{0, 32'h0,        0, 1, 1, 16'h0000, 32'h80000000, 1, 0};
    tbl[11] = '{0, 32'h0,        0, 1, 1, 16'h8000, 32'h80000000, 0, 0};
    tbl[12] = '{0, 32'h0,        0, 1, 1, 16'h0000, 32'h80000000, 1, 0};
    ps_exp  = '{16'h0000, 16'h0000, 16'h1000, 16'h2000,
                16'h3000, 16'h0000, 16'h2000, 16'h4000};

    reset    = 1'b1;
    s_tvalid = 0;
    s_tdata  = 0;
    s_tlast  = 0;
    m_tready = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("init_tready", 32'(s_tready), 32'd0);
    chk("init_tvalid", 32'(m_tvalid), 32'd0);
    chk("init_level", 32'(fifo_level), 32'd0);
    reset = 1'b0;
    #1;
    chk("rel_tready", 32'(s_tready), 32'd1);

    // Accumulation, stop and wrap vectors
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].mr);
      chk($sformatf("v%0d_tvalid", i), 32'(m_tvalid), 32'(tbl[i].e_valid));
      chk($sformatf("v%0d_tdata", i), 32'(m_tdata), 32'(tbl[i].e_data));
      chk($sformatf("v%0d_inc", i), active_inc, tbl[i].e_inc);
      chk($sformatf("v%0d_wrap", i), 32'(phase_wrap), 32'(tbl[i].e_wrap));
      chk($sformatf("v%0d_lvl", i), 32'(fifo_level), 32'(tbl[i].e_lvl));
    end

    // Backpressure: six offers, four land, data frozen
    for (int i = 0; i < 6; i++) begin
      step(1, 32'h01000000 + 32'(i), 0, 0);
      chk("bp_tdata", 32'(m_tdata), 32'h0000);
    end
    chk("bp_level", 32'(fifo_level), 32'd4);
    chk("bp_tready", 32'(s_tready), 32'd0);
    step(1, 32'h0A000000, 0, 1);
    chk("bp_pop_level", 32'(fifo_level), 32'd3);
    chk("bp_reopen", 32'(s_tready), 32'd1);
    chk("bp_pop_inc", active_inc, 32'h01000000);
    chk("bp_pop_tdata", 32'(m_tdata), 32'h8000);

    // Asynchronous reset with three beats queued
    reset_now();
    step(0, 0, 0, 1);
    chk("post_rst_tready", 32'(s_tready), 32'd1);
    chk("post_rst_tvalid", 32'(m_tvalid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1);
      chk("no_stale", 32'(m_tvalid), 32'd0);
    end

    // Phase sync on a tlast beat
    for (int i = 0; i < 8; i++) begin
      step(i == 0 || i == 4,
           (i == 0) ? 32'h10000000 : 32'h20000000,
           i == 4, 1);
      if (i > 0) chk($sformatf("sync%0d", i), 32'(m_tdata), 32'(ps_exp[i]));
    end

    // Stop, then restart from zero
    step(1, 32'h0, 0, 1);
    chk("stop_tdata", 32'(m_tdata), 32'h6000);
    step(0, 0, 0, 1);
    chk("stop_tvalid", 32'(m_tvalid), 32'd0);
    step(1, 32'h0051EB85, 0, 1);
    chk("restart_wait", 32'(m_tvalid), 32'd0);
    step(0, 0, 0, 1);
    chk("restart_tvalid", 32'(m_tvalid), 32'd1);
    chk("restart_tdata", 32'(m_tdata), 32'h0000);
    chk("restart_inc", active_inc, 32'h0051EB85);

    // Randomized traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] d;
      d = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      if (i % 1000 == 999) begin
        reset_now();
      end else begin
        step($urandom_range(0, 2) != 0, d,
             $urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
